accum_sequencer: RTL and testbench

Sequencing controller for the board-level add/subtract datapath. It turns pushbutton presses into single add, subtract or clear commands on an 8-bit saturating accumulator, using a 4-bit switch operand. After each update it runs a sequential binary-to-BCD conversion, so the hex_7seg display path always shows a settled decimal value. It sits between the KEY/SW inputs and the display decoders, replacing the free-running combinational adder-to-BCD chain.

---
 rtl/calc_pkg.sv | 44 ++++
 rtl/accum_sequencer_if.sv | 43 ++++
 rtl/dabble_seq.sv | 94 +++++++++
 rtl/accum_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_accum_sequencer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared constants, state/command types and a small priority helper for the
// accum_sequencer block and its dabble_seq converter.
//   ACC_W       accumulator width (8)
//   OP_W        operand width (4)
//   CONV_CYCLES binary-to-BCD iterations, one per input bit (8)
//   BCD_W       hundreds(2) + tens(4) + ones(4) scratch width
// -----------------------------------------------------------------------------
package calc_pkg;

  localparam int ACC_W       = 8;
  localparam int OP_W        = 4;
  localparam int CONV_CYCLES = 8;
  localparam int BCD_W       = 10;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    CONV
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE,
    ADD,
    SUB,
    CLR
  } cmd_t;

  // Same-cycle presses resolve as clr > sub > add.
  function automatic cmd_t pick_cmd(input logic clr, input logic sub, input logic add);
    cmd_t c;
    c = NONE;
    if (clr) begin
      c = CLR;
    end else if (sub) begin
      c = SUB;
    end else if (add) begin
      c = ADD;
    end
    return c;
  endfunction

endpackage

// File: rtl/accum_sequencer_if.sv
// -----------------------------------------------------------------------------
// accum_sequencer_if
// Board-side bundle between the KEY/SW inputs, the accumulator and the
// display decoders.
//   key_add/key_sub/key_clr  active-low pushbuttons (master -> slave)
//   operand[3:0]             unsigned operand (master -> slave)
//   acc[7:0], ovf            accumulator and sticky saturation flag
//   ones/tens/hundreds       BCD digits of acc
//   busy, bcd_valid          sequencing status
//   dbg_state                current sequencer state, for observation only
//
// Protocol: a command is a key press (falling level). A press is accepted
// only while busy is low; presses seen while busy is high are dropped, never
// queued. bcd_valid high means the three digits equal the decimal value of
// acc; it drops for the whole execute/convert window of every command.
// -----------------------------------------------------------------------------
interface accum_sequencer_if;
  import calc_pkg::*;

  logic             key_add;
  logic             key_sub;
  logic             key_clr;
  logic [OP_W-1:0]  operand;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [3:0]       ones;
  logic [3:0]       tens;
  logic [1:0]       hundreds;
  logic             busy;
  logic             bcd_valid;
  seq_state_t       dbg_state;

  modport master (
    output key_add, key_sub, key_clr, operand,
    input  acc, ovf, ones, tens, hundreds, busy, bcd_valid, dbg_state
  );

  modport slave (
    input  key_add, key_sub, key_clr, operand,
    output acc, ovf, ones, tens, hundreds, busy, bcd_valid, dbg_state
  );

endinterface

// File: rtl/dabble_seq.sv
// -----------------------------------------------------------------------------
// dabble_seq
// Sequential shift-add-3 (double dabble) binary-to-BCD converter, one input
// bit per cycle, MSB first, CONV_CYCLES iterations after start.
//   CLOCK_50  in   clock
//   rst       in   asynchronous active-high reset
//   start     in   1-cycle pulse; bin is captured on this edge
//   bin[7:0]  in   value to convert
//   done      out  1-cycle pulse during the last iteration
//   ones/tens/hundreds out  digit registers, loaded only when done is high
// -----------------------------------------------------------------------------
module dabble_seq
  import calc_pkg::*;
(
  input  logic             CLOCK_50,
  input  logic             rst,
  input  logic             start,
  input  logic [ACC_W-1:0] bin,
  output logic             done,
  output logic [3:0]       ones,
  output logic [3:0]       tens,
  output logic [1:0]       hundreds
);

  logic             running_q, running_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_step;
  logic [3:0]       ones_q, tens_q;
  logic [1:0]       hundreds_q;

  always_comb begin
    // Add-3 on every digit >= 5 before the shift. The hundreds digit is at
    // most 1 before the final shift for 8-bit inputs, so it never needs it.
    bcd_adj = bcd_q;
    if (bcd_q[3:0] >= 4'd5) begin
      bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
    end
    if (bcd_q[7:4] >= 4'd5) begin
      bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end
    bcd_step = {bcd_adj[BCD_W-2:0], sh_q[ACC_W-1]};

    done      = running_q && (cnt_q == 3'(CONV_CYCLES - 1));
    running_d = running_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    bcd_d     = bcd_q;

    if (start) begin
      running_d = 1'b1;
      cnt_d     = 3'd0;
      sh_d      = bin;
      bcd_d     = '0;
    end else if (running_q) begin
      sh_d  = {sh_q[ACC_W-2:0], 1'b0};
      bcd_d = bcd_step;
      cnt_d = cnt_q + 3'd1;
      if (done) begin
        running_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      running_q  <= 1'b0;
      cnt_q      <= 3'd0;
      sh_q       <= '0;
      bcd_q      <= '0;
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      hundreds_q <= 2'd0;
    end else begin
      running_q <= running_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      bcd_q     <= bcd_d;
      // The final iteration's result goes straight into the digit registers.
      if (done) begin
        hundreds_q <= bcd_step[9:8];
        tens_q     <= bcd_step[7:4];
        ones_q     <= bcd_step[3:0];
      end
    end
  end

  assign ones     = ones_q;
  assign tens     = tens_q;
  assign hundreds = hundreds_q;

endmodule

// File: rtl/accum_sequencer.sv
// -----------------------------------------------------------------------------
// accum_sequencer
// Turns pushbutton presses into single add / subtract / clear commands on an
// 8-bit saturating accumulator, then runs a sequential binary-to-BCD
// conversion so the display digits always show a settled decimal value.
//   DEB_CYCLES  stable-level cycles before a key change is believed
//               (only meaningful with DEBOUNCE_EN)
//   CLOCK_50    in  the only clock
//   rst         in  asynchronous active-high reset
//   bus         slave side of accum_sequencer_if (keys, operand, acc, ovf,
//               digits, busy, bcd_valid, dbg_state)
// Build option: define DEBOUNCE_EN to insert a per-key debouncer between the
// synchronizer and the falling-edge detector.
// -----------------------------------------------------------------------------
module accum_sequencer
  import calc_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic            CLOCK_50,
  input  logic            rst,
  accum_sequencer_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Key front end, bit order {clr, sub, add}
  // ---------------------------------------------------------------------------
  logic [2:0] keys_raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level;
  logic [2:0] prev_q;
  logic [2:0] press;

  assign keys_raw = {bus.key_clr, bus.key_sub, bus.key_add};

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
      prev_q  <= 3'b000;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
      prev_q  <= level;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);

  logic [DEB_W-1:0] deb_cnt_q [3];
  logic [DEB_W-1:0] deb_cnt_d [3];
  logic [2:0]       deb_lvl_q, deb_lvl_d;

  // The filtered level follows the synchronized key only once the two have
  // disagreed long enough; any agreement (a bounce back) restarts the count.
  always_comb begin
    deb_lvl_d = deb_lvl_q;
    for (int k = 0; k < 3; k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != deb_lvl_q[k]) begin
        if (deb_cnt_q[k] == DEB_W'(DEB_CYCLES)) begin
          deb_lvl_d[k] = sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DEB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      deb_lvl_q <= 3'b000;
      for (int k = 0; k < 3; k++) begin
        deb_cnt_q[k] <= '0;
      end
    end else begin
      deb_lvl_q <= deb_lvl_d;
      for (int k = 0; k < 3; k++) begin
        deb_cnt_q[k] <= deb_cnt_d[k];
      end
    end
  end

  assign level = deb_lvl_q;
`else
  logic unused_deb_cfg;
  assign unused_deb_cfg = (DEB_CYCLES != 0);
  assign level          = sync2_q;
`endif

  // Reset clears the edge history to 0 (pressed), so an idle key coming out
  // of reset rises and never looks like a press.
  assign press = prev_q & ~level;

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  seq_state_t       state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  cmd_t             new_cmd;
  logic [OP_W-1:0]  op_q, op_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic             conv_start;
  logic             conv_done;
  logic [ACC_W:0]   sum9;
  logic [ACC_W:0]   diff9;

  assign new_cmd = pick_cmd(press[2], press[1], press[0]);

  // Bit ACC_W of sum9 is the carry (> 255); of diff9 it is the borrow (< 0).
  assign sum9  = {1'b0, acc_q} + {{(ACC_W + 1 - OP_W){1'b0}}, op_q};
  assign diff9 = {1'b0, acc_q} - {{(ACC_W + 1 - OP_W){1'b0}}, op_q};

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    op_d       = op_q;
    acc_d      = acc_q;
    ovf_d      = ovf_q;
    conv_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (new_cmd != NONE) begin
          cmd_d   = new_cmd;
          op_d    = bus.operand;
          state_d = EXEC;
        end
      end

      EXEC: begin
        conv_start = 1'b1;
        state_d    = CONV;
        unique case (cmd_q)
          ADD: begin
            if (sum9[ACC_W]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum9[ACC_W-1:0];
            end
          end
          SUB: begin
            if (diff9[ACC_W]) begin
              acc_d = '0;
              ovf_d = 1'b1;
            end else begin
              acc_d = diff9[ACC_W-1:0];
            end
          end
          CLR: begin
            acc_d = '0;
            ovf_d = 1'b0;
          end
          default: begin
          end
        endcase
      end

      CONV: begin
        if (conv_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cmd_q   <= NONE;
      op_q    <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // The converter captures acc_d so it starts on the value being written
  // in the same EXEC edge.
  dabble_seq u_dabble (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .start    (conv_start),
    .bin      (acc_d),
    .done     (conv_done),
    .ones     (bus.ones),
    .tens     (bus.tens),
    .hundreds (bus.hundreds)
  );

  assign bus.acc       = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.bcd_valid = (state_q == IDLE);
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_accum_sequencer.sv
// -----------------------------------------------------------------------------
// tb_accum_sequencer
// Directed and randomized stimulus for accum_sequencer. A reference model
// keeps the accumulator as a plain integer and derives the decimal digits
// with / and %. Inputs change and outputs are sampled on the falling edge.
// With DEBOUNCE_EN defined the DUT is built with DEB_CYCLES = 4 and the key
// timing below stretches accordingly.
// -----------------------------------------------------------------------------
module tb_accum_sequencer;
  import calc_pkg::*;

  localparam int DEB = 4;
`ifdef DEBOUNCE_EN
  localparam int PL   = 2 + DEB + 1;  // cycle of the internal press pulse
  localparam int HOLD = 6;            // key held low for this many cycles
  localparam int TAIL = 10;           // extra idle so releases settle
`else
  localparam int PL   = 2;
  localparam int HOLD = 1;
  localparam int TAIL = 0;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLOCK_50 = 1'b0;
  logic rst;
  always #10 CLOCK_50 = ~CLOCK_50;

  accum_sequencer_if bus ();

  accum_sequencer #(.DEB_CYCLES(DEB)) dut (
    .CLOCK_50 (CLOCK_50),
    .rst      (rst),
    .bus      (bus)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard and model
  // ---------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int m_acc    = 0;
  bit m_ovf    = 1'b0;
  logic [ACC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_cmd(input logic [2:0] mask, input int op);
    int r;
    if (mask[2]) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end else if (mask[1]) begin
      r = m_acc - op;
      if (r < 0) begin
        m_acc = 0;
        m_ovf = 1'b1;
      end else begin
        m_acc = r;
      end
    end else if (mask[0]) begin
      r = m_acc + op;
      if (r > 255) begin
        m_acc = 255;
        m_ovf = 1'b1;
      end else begin
        m_acc = r;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_acc"},  32'(bus.acc), 32'(m_acc));
    check({tag, "_ovf"},  32'(bus.ovf), 32'(m_ovf));
    check({tag, "_ones"}, 32'(bus.ones), 32'(m_acc % 10));
    check({tag, "_tens"}, 32'(bus.tens), 32'((m_acc / 10) % 10));
    check({tag, "_hund"}, 32'(bus.hundreds), 32'(m_acc / 100));
    check({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_bval"}, 32'(bus.bcd_valid), 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // Drivers
  // ---------------------------------------------------------------------------
  task automatic drive_keys(input logic [2:0] mask);
    bus.key_clr = ~mask[2];
    bus.key_sub = ~mask[1];
    bus.key_add = ~mask[0];
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLOCK_50);
    end
  endtask

  // One press of the keys in mask ({clr,sub,add}) with operand op. While the
  // command is busy, busy_mask is pressed (must be dropped) and the operand
  // is changed to op_late (must have no effect).
  task automatic do_cmd(input logic [2:0] mask, input int op,
                        input logic [2:0] busy_mask, input int op_late);
    bit active;
    active = (mask != 3'b000);
    for (int c = 0; c <= PL + 10 + TAIL; c++) begin
      @(negedge CLOCK_50);
      if (c == 0) begin
        check("pre_busy", 32'(bus.busy), 32'd0);
        bus.operand = 4'(op);
        drive_keys(mask);
      end
      if (c == HOLD) drive_keys(3'b000);
      if (c == PL && active) begin
        model_cmd(mask, op);
        exp_q.push_back(8'(m_acc));
      end
      if (c == PL + 1) begin
        check("busy_n1", 32'(bus.busy), 32'(active));
        check("bval_n1", 32'(bus.bcd_valid), 32'(!active));
        if (active) drive_keys(busy_mask);
        bus.operand = 4'(op_late);
      end
      if (c == PL + 1 + HOLD) drive_keys(3'b000);
      if (c == PL + 2 && active) begin
        check("acc_n2", 32'(bus.acc), 32'(exp_q.pop_front()));
        check("ovf_n2", 32'(bus.ovf), 32'(m_ovf));
      end
      if (c == PL + 9) check("bval_n9", 32'(bus.bcd_valid), 32'(!active));
      if (c == PL + 10) check_idle("done");
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [2:0] mask;
    logic [2:0] bmask;
    int         op;
    int         busy_cnt;
    bit         busy_prev;

    rst = 1'b1;
    bus.operand = 4'd0;
    drive_keys(3'b000);
    idle_cycles(3);
    rst = 1'b0;
    idle_cycles(1);
    check_idle("reset");
    check("reset_state", 32'(bus.dbg_state), 32'(IDLE));
    idle_cycles(2 + TAIL);

    // Three adds of 9.
    for (int i = 0; i < 3; i++) do_cmd(3'b001, 9, 3'b000, 9);
    check("acc27", 32'(bus.acc), 32'd27);
    check("ones7", 32'(bus.ones), 32'd7);
    check("tens2", 32'(bus.tens), 32'd2);

    // Build up to 250, then saturate high, then clear.
    do_cmd(3'b100, 0, 3'b000, 0);
    for (int i = 0; i < 16; i++) do_cmd(3'b001, 15, 3'b000, 15);
    do_cmd(3'b001, 10, 3'b000, 10);
    check("acc250", 32'(bus.acc), 32'd250);
    do_cmd(3'b001, 9, 3'b000, 9);
    check("sat_acc", 32'(bus.acc), 32'd255);
    check("sat_ovf", 32'(bus.ovf), 32'd1);
    check("sat_digits", 32'({bus.hundreds, bus.tens, bus.ones}), 32'({2'd2, 4'd5, 4'd5}));
    do_cmd(3'b100, 0, 3'b000, 0);
    check("clr_acc", 32'(bus.acc), 32'd0);
    check("clr_ovf", 32'(bus.ovf), 32'd0);

    // Exact 255 and exact 0 do not set ovf.
    for (int i = 0; i < 17; i++) do_cmd(3'b001, 15, 3'b000, 0);
    check("exact255_ovf", 32'(bus.ovf), 32'd0);
    do_cmd(3'b100, 0, 3'b000, 0);
    do_cmd(3'b001, 5, 3'b000, 0);
    do_cmd(3'b010, 5, 3'b000, 0);
    check("exact0_ovf", 32'(bus.ovf), 32'd0);

    // Underflow, then sticky ovf.
    do_cmd(3'b001, 3, 3'b000, 3);
    do_cmd(3'b010, 5, 3'b000, 5);
    check("under_acc", 32'(bus.acc), 32'd0);
    check("under_ovf", 32'(bus.ovf), 32'd1);
    do_cmd(3'b001, 15, 3'b000, 15);
    do_cmd(3'b001, 15, 3'b000, 15);
    check("sticky_acc", 32'(bus.acc), 32'd30);
    check("sticky_ovf", 32'(bus.ovf), 32'd1);

    // add+sub together with acc 10: sub wins; a busy press is dropped.
    do_cmd(3'b010, 15, 3'b000, 15);
    do_cmd(3'b010, 5, 3'b000, 5);
    do_cmd(3'b011, 4, 3'b001, 4);
    check("prio_acc", 32'(bus.acc), 32'd6);
    // clr beats add.
    do_cmd(3'b101, 7, 3'b000, 7);
    check("prio_clr", 32'(bus.acc), 32'd0);
    do_cmd(3'b001, 6, 3'b000, 6);
    do_cmd(3'b010, 9, 3'b000, 9);
    do_cmd(3'b001, 6, 3'b000, 6);
    // add 0 still runs the full sequence (busy checks inside do_cmd).
    do_cmd(3'b001, 0, 3'b010, 3);
    check("add0_acc", 32'(bus.acc), 32'd6);

    // Reset in the 4th conversion cycle.
    for (int c = 0; c <= PL + 5; c++) begin
      @(negedge CLOCK_50);
      if (c == 0) begin
        bus.operand = 4'd7;
        drive_keys(3'b001);
      end
      if (c == HOLD) drive_keys(3'b000);
      if (c == PL) model_cmd(3'b001, 7);
      if (c == PL + 2) check("rst_pre_acc", 32'(bus.acc), 32'(m_acc));
      if (c == PL + 5) begin
        check("rst_pre_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        m_acc = 0;
        m_ovf = 1'b0;
        check_idle("rst_async");
        check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
      end
    end
    @(negedge CLOCK_50);
    rst = 1'b0;
    idle_cycles(4 + TAIL);
    check_idle("rst_after");
    do_cmd(3'b001, 11, 3'b000, 2);
    check("rst_next_acc", 32'(bus.acc), 32'd11);

`ifdef DEBOUNCE_EN
    // Bouncing key: never stable long enough, so no command.
    bus.operand = 4'd3;
    busy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge CLOCK_50);
      if (bus.busy) busy_cnt++;
      bus.key_add = (c < 12) ? (((c / 2) % 2) != 0) : 1'b1;
    end
    check("bounce_busy", 32'(busy_cnt), 32'd0);
    check("bounce_acc", 32'(bus.acc), 32'(m_acc));
    // Held low for 6 cycles: exactly one command, release adds none.
    busy_cnt  = 0;
    busy_prev = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge CLOCK_50);
      if (bus.busy && !busy_prev) busy_cnt++;
      busy_prev = bus.busy;
      bus.key_add = (c >= 6);
    end
    model_cmd(3'b001, 3);
    check("deb_one_cmd", 32'(busy_cnt), 32'd1);
    check_idle("deb_hold");
`else
    busy_cnt  = 0;
    busy_prev = 1'b0;
`endif

    // Randomized commands against the model.
    for (int i = 0; i < 30; i++) begin
      mask  = 3'($urandom_range(0, 7));
      op    = $urandom_range(0, 15);
      bmask = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'b000;
      do_cmd(mask, op, bmask, $urandom_range(0, 15));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
